// File: rtl/riscv_mem_stage.sv
// riscv_mem_stage: pipeline MEM stage.
// Captures EX results and tracks the single outstanding data-memory access.
// Formats returned load data and maps dmem error responses onto cause bits.
// Optional feature: define RISCV_MEM_STALL_CNT_EN to build a saturating
// stall-cycle counter on mem_stall_cnt; otherwise that output is tied to 0.
module riscv_mem_stage #(
  parameter int              XLEN           = 32,
  parameter int              ILEN           = 32,
  parameter int              EXCEPTION_SIZE = 16,
  parameter logic [XLEN-1:0] PC_INIT        = 'h200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_stall,
  output logic                      mem_stall,
  input  logic                      mem_flush,
  input  logic [XLEN-1:0]           ex_pc,
  input  logic [ILEN-1:0]           ex_instr,
  input  logic                      ex_bubble,
  input  logic [EXCEPTION_SIZE-1:0] ex_exception,
  input  logic [XLEN-1:0]           ex_r,
  input  logic                      ex_ld,
  input  logic                      ex_st,
  input  logic [2:0]                ex_funct3,
  input  logic [2:0]                ex_adr_lsb,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_q,
  input  logic                      dmem_misaligned,
  input  logic                      dmem_page_fault,
  output logic [XLEN-1:0]           mem_pc,
  output logic [ILEN-1:0]           mem_instr,
  output logic                      mem_bubble,
  output logic [EXCEPTION_SIZE-1:0] mem_exception,
  output logic [XLEN-1:0]           mem_r,
  output logic [31:0]               mem_stall_cnt
);

  // RISC-V cause codes used as bit indices into the exception vector
  localparam int CAUSE_LD_MISALIGNED = 4;
  localparam int CAUSE_ST_MISALIGNED = 6;
  localparam int CAUSE_LD_PAGE_FAULT = 13;
  localparam int CAUSE_ST_PAGE_FAULT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                    state_q;
  logic [XLEN-1:0]           pc_q;
  logic [ILEN-1:0]           instr_q;
  logic                      bubble_q;
  logic [EXCEPTION_SIZE-1:0] exc_q;
  logic [XLEN-1:0]           r_q;
  logic [2:0]                funct3_q;
  logic [2:0]                lsb_q;
  logic                      is_ld_q;

  logic [2:0]                lsb_eff;
  logic [5:0]                shamt;
  logic [XLEN-1:0]           shifted;
  logic [XLEN-1:0]           ld_data_d;

  // Stall depends only on state and WB backpressure, never on the ack
  assign mem_stall = wb_stall | (state_q != IDLE);

  assign mem_pc        = pc_q;
  assign mem_instr     = instr_q;
  assign mem_bubble    = bubble_q;
  assign mem_exception = exc_q;
  assign mem_r         = r_q;

  // Byte lane select: bit 2 of the address only matters on a 64-bit bus
  assign lsb_eff = {lsb_q[2] & (XLEN == 64), lsb_q[1:0]};
  assign shamt   = {lsb_eff, 3'b000};
  assign shifted = dmem_q >> shamt;

  // Format returned load data by the latched funct3 and byte lane
  always_comb begin
    // NOTE: default assignment first so every path drives ld_data_d and no latch is inferred.
    ld_data_d = dmem_q;
    case (funct3_q)
      3'b000:  ld_data_d = XLEN'($signed(shifted[7:0]));
      3'b001:  ld_data_d = XLEN'($signed(shifted[15:0]));
      3'b100:  ld_data_d = XLEN'(shifted[7:0]);
      3'b101:  ld_data_d = XLEN'(shifted[15:0]);
      3'b010:  if (XLEN == 64) ld_data_d = XLEN'($signed(shifted[31:0]));
      3'b110:  if (XLEN == 64) ld_data_d = XLEN'(shifted[31:0]);
      default: ld_data_d = dmem_q;
    endcase
  end

  // Stage registers and access-tracking FSM
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= PC_INIT;
      instr_q  <= ILEN'(32'h13);
      bubble_q <= 1'b1;
      exc_q    <= '0;
      r_q      <= '0;
      funct3_q <= 3'b000;
      lsb_q    <= 3'b000;
      is_ld_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_flush) begin
            bubble_q <= 1'b1;
            exc_q    <= '0;
          end else if (!wb_stall) begin
            pc_q     <= ex_pc;
            instr_q  <= ex_instr;
            bubble_q <= ex_bubble;
            exc_q    <= ex_exception;
            r_q      <= ex_r;
            if (!ex_bubble && (ex_ld || ex_st)) begin
              funct3_q <= ex_funct3;
              lsb_q    <= ex_adr_lsb;
              is_ld_q  <= ex_ld;
              state_q  <= WAIT;
            end
          end
        end

        WAIT: begin
          if (mem_flush) begin
            // A same-cycle ack is consumed here; otherwise drain it later
            bubble_q <= 1'b1;
            exc_q    <= '0;
            state_q  <= dmem_ack ? IDLE : DRAIN;
          end else if (dmem_ack) begin
            state_q <= IDLE;
            if (dmem_misaligned) begin
              if (is_ld_q) exc_q[CAUSE_LD_MISALIGNED] <= 1'b1;
              else         exc_q[CAUSE_ST_MISALIGNED] <= 1'b1;
            end
            if (dmem_page_fault) begin
              if (is_ld_q) exc_q[CAUSE_LD_PAGE_FAULT] <= 1'b1;
              else         exc_q[CAUSE_ST_PAGE_FAULT] <= 1'b1;
            end
            // Faulting accesses leave the address result in place
            if (is_ld_q && !dmem_misaligned && !dmem_page_fault) begin
              r_q <= ld_data_d;
            end
          end
        end

        DRAIN: begin
          if (dmem_ack) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RISCV_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles spent outside IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q != IDLE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign mem_stall_cnt = stall_cnt_q;
`else
  assign mem_stall_cnt = 32'd0;
`endif

endmodule
